// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 device-side responder: command classes,
// command field positions and the frame FSM encoding.
package tm1638_pkg;

    // Command class, byte bits [7:6]
    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_DISP = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    // Data command operation, byte bits [1:0]; 01 and 11 are reserved
    localparam logic [1:0] DATA_OP_WRITE = 2'b00;
    localparam logic [1:0] DATA_OP_READ  = 2'b10;

    localparam int unsigned BIT_FIXED   = 2;
    localparam int unsigned BIT_DISP_ON = 3;
    localparam int unsigned LEVEL_MSB   = 2;
    localparam int unsigned LEVEL_LSB   = 0;

    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned KEY_BITS = 32;
    localparam int unsigned RD_CNT_W = $clog2(KEY_BITS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWdata,
        StRdata,
        StIgnore
    } state_e;

endpackage

// File: rtl/tm1638_input_sync.sv
// Multi-flop synchroniser for one asynchronous serial-link input, with
// single-cycle rise/fall pulses derived from the synchronised level.
module tm1638_input_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stages_q, stages_d;
    logic                   prev_q, prev_d;

    always_comb begin
        stages_d = {stages_q[SYNC_STAGES-2:0], async_in};
        prev_d   = stages_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q   <= RESET_VAL;
        end else begin
            stages_q <= stages_d;
            prev_q   <= prev_d;
        end
    end

    assign sync_out = stages_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~prev_q;
    assign fall     = ~sync_out & prev_q;

endmodule

// File: rtl/tm1638_device_responder.sv
// TM1638 device-side responder: decodes controller frames, holds display RAM and
// display control state, and shifts key-scan bytes back on read commands.
module tm1638_device_responder
    import tm1638_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RAM_BYTES   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tm1638_strobe,
    input  logic                   tm1638_clk,
    inout  wire                    tm1638_data_io,
    input  logic [KEY_BITS-1:0]    key_scan,
    output logic [8*RAM_BYTES-1:0] display_ram,
    output logic                   display_on,
    output logic [2:0]             display_level,
    output logic                   ram_wr,
    output logic [ADDR_W-1:0]      ram_wr_addr,
    output logic                   frame_done,
    output logic                   cmd_error
);

    logic stb_s, stb_rise, stb_fall;
    logic clk_s, clk_rise, clk_fall;
    logic dio_s, dio_rise, dio_fall;

    tm1638_input_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_VAL  (1'b1)
    ) u_sync_stb (
        .clk     (clk),
        .rst     (rst),
        .async_in(tm1638_strobe),
        .sync_out(stb_s),
        .rise    (stb_rise),
        .fall    (stb_fall)
    );

    tm1638_input_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_VAL  (1'b1)
    ) u_sync_clk (
        .clk     (clk),
        .rst     (rst),
        .async_in(tm1638_clk),
        .sync_out(clk_s),
        .rise    (clk_rise),
        .fall    (clk_fall)
    );

    tm1638_input_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_VAL  (1'b1)
    ) u_sync_dio (
        .clk     (clk),
        .rst     (rst),
        .async_in(tm1638_data_io),
        .sync_out(dio_s),
        .rise    (dio_rise),
        .fall    (dio_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{clk_s, dio_rise, dio_fall};

    state_e                        state_q, state_d;
    logic [7:0]                    shift_q, shift_d;
    logic [2:0]                    bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0]             addr_q, addr_d;
    logic                          fixed_q, fixed_d;
    logic [KEY_BITS-1:0]           rd_shift_q, rd_shift_d;
    logic [RD_CNT_W-1:0]           rd_cnt_q, rd_cnt_d;
    logic                          dio_oe_q, dio_oe_d;
    logic                          dio_out_q, dio_out_d;
    logic [RAM_BYTES-1:0][7:0]     ram_q, ram_d;
    logic                          disp_on_q, disp_on_d;
    logic [2:0]                    disp_level_q, disp_level_d;
    logic                          ram_wr_q, ram_wr_d;
    logic [ADDR_W-1:0]             ram_wr_addr_q, ram_wr_addr_d;
    logic                          frame_done_q, frame_done_d;
    logic                          cmd_error_q, cmd_error_d;

    logic       bit_rise, bit_fall;
    logic [7:0] byte_in;

    // Link clock edges only count while the strobe is held low.
    assign bit_rise = clk_rise & ~stb_s;
    assign bit_fall = clk_fall & ~stb_s;
    assign byte_in  = {dio_s, shift_q[7:1]};

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        addr_d        = addr_q;
        fixed_d       = fixed_q;
        rd_shift_d    = rd_shift_q;
        rd_cnt_d      = rd_cnt_q;
        dio_oe_d      = dio_oe_q;
        dio_out_d     = dio_out_q;
        ram_d         = ram_q;
        disp_on_d     = disp_on_q;
        disp_level_d  = disp_level_q;
        ram_wr_d      = 1'b0;
        ram_wr_addr_d = ram_wr_addr_q;
        frame_done_d  = 1'b0;
        cmd_error_d   = 1'b0;

        // Strobe release ends the frame from any state and drops any partial byte.
        if (stb_rise) begin
            state_d      = StIdle;
            dio_oe_d     = 1'b0;
            frame_done_d = 1'b1;
            bit_cnt_d    = '0;
            shift_d      = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (stb_fall) begin
                        state_d   = StCmd;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end
                end
                StCmd, StWdata, StIgnore: begin
                    if (bit_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == StCmd) begin
                                unique case (byte_in[7:6])
                                    CMD_DATA: begin
                                        state_d = StIgnore;
                                        unique case (byte_in[1:0])
                                            DATA_OP_WRITE: fixed_d = byte_in[BIT_FIXED];
                                            DATA_OP_READ: begin
                                                rd_shift_d = key_scan;
                                                rd_cnt_d   = '0;
                                                state_d    = StRdata;
                                            end
                                            default: cmd_error_d = 1'b1;
                                        endcase
                                    end
                                    CMD_DISP: begin
                                        disp_on_d    = byte_in[BIT_DISP_ON];
                                        disp_level_d = byte_in[LEVEL_MSB:LEVEL_LSB];
                                        state_d      = StIgnore;
                                    end
                                    CMD_ADDR: begin
                                        addr_d  = byte_in[ADDR_W-1:0];
                                        state_d = StWdata;
                                    end
                                    default: begin
                                        cmd_error_d = 1'b1;
                                        state_d     = StIgnore;
                                    end
                                endcase
                            end else if (state_q == StWdata) begin
                                ram_d[addr_q] = byte_in;
                                ram_wr_d      = 1'b1;
                                ram_wr_addr_d = addr_q;
                                if (!fixed_q) begin
                                    addr_d = addr_q + 1'b1;
                                end
                            end
                        end
                    end
                end
                StRdata: begin
                    // After the last key bit, the following falling edge releases DIO.
                    if (bit_fall) begin
                        if (rd_cnt_q != RD_CNT_W'(KEY_BITS)) begin
                            dio_oe_d   = 1'b1;
                            dio_out_d  = rd_shift_q[0];
                            rd_shift_d = rd_shift_q >> 1;
                            rd_cnt_d   = rd_cnt_q + 1'b1;
                        end else begin
                            dio_oe_d = 1'b0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            addr_q        <= '0;
            fixed_q       <= 1'b0;
            rd_shift_q    <= '0;
            rd_cnt_q      <= '0;
            dio_oe_q      <= 1'b0;
            dio_out_q     <= 1'b0;
            ram_q         <= '0;
            disp_on_q     <= 1'b0;
            disp_level_q  <= '0;
            ram_wr_q      <= 1'b0;
            ram_wr_addr_q <= '0;
            frame_done_q  <= 1'b0;
            cmd_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            addr_q        <= addr_d;
            fixed_q       <= fixed_d;
            rd_shift_q    <= rd_shift_d;
            rd_cnt_q      <= rd_cnt_d;
            dio_oe_q      <= dio_oe_d;
            dio_out_q     <= dio_out_d;
            ram_q         <= ram_d;
            disp_on_q     <= disp_on_d;
            disp_level_q  <= disp_level_d;
            ram_wr_q      <= ram_wr_d;
            ram_wr_addr_q <= ram_wr_addr_d;
            frame_done_q  <= frame_done_d;
            cmd_error_q   <= cmd_error_d;
        end
    end

    assign tm1638_data_io = dio_oe_q ? dio_out_q : 1'bz;
    assign display_ram    = ram_q;
    assign display_on     = disp_on_q;
    assign display_level  = disp_level_q;
    assign ram_wr         = ram_wr_q;
    assign ram_wr_addr    = ram_wr_addr_q;
    assign frame_done     = frame_done_q;
    assign cmd_error      = cmd_error_q;

endmodule

// File: tb/tb_tm1638_device_responder.sv
// Directed bench for the TM1638 device responder: plays the controller side of
// the link and checks RAM, display control, pulses and read-back data.
module tb_tm1638_device_responder;

    localparam time HALF = 80;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tm_stb = 1'b1;
    logic         tm_clk = 1'b1;
    logic         ctl_oe = 1'b0;
    logic         ctl_bit = 1'b0;
    logic [31:0]  key_scan = '0;
    wire          dio;
    logic [127:0] display_ram;
    logic         display_on;
    logic [2:0]   display_level;
    logic         ram_wr;
    logic [3:0]   ram_wr_addr;
    logic         frame_done;
    logic         cmd_error;

    assign dio = ctl_oe ? ctl_bit : 1'bz;
    pullup (dio);

    always #5 clk = ~clk;

    tm1638_device_responder dut (
        .clk           (clk),
        .rst           (rst),
        .tm1638_strobe (tm_stb),
        .tm1638_clk    (tm_clk),
        .tm1638_data_io(dio),
        .key_scan      (key_scan),
        .display_ram   (display_ram),
        .display_on    (display_on),
        .display_level (display_level),
        .ram_wr        (ram_wr),
        .ram_wr_addr   (ram_wr_addr),
        .frame_done    (frame_done),
        .cmd_error     (cmd_error)
    );

    int         n_wr = 0;
    int         n_frame = 0;
    int         n_err = 0;
    logic [3:0] wr_log[$];

    always @(posedge clk) begin
        if (ram_wr) begin
            n_wr++;
            wr_log.push_back(ram_wr_addr);
        end
        if (frame_done) n_frame++;
        if (cmd_error) n_err++;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            tm_clk = 1'b0;
            #(HALF / 2);
            ctl_oe  = 1'b1;
            ctl_bit = b[i];
            #(HALF / 2);
            tm_clk = 1'b1;
            #HALF;
        end
        ctl_oe = 1'b0;
    endtask

    task automatic start_frame();
        tm_stb = 1'b0;
        #HALF;
    endtask

    task automatic end_frame();
        tm_stb = 1'b1;
        #(2 * HALF);
    endtask

    task automatic frame1(input logic [7:0] b);
        start_frame();
        send_bits(b, 8);
        end_frame();
    endtask

    task automatic read_byte(output logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            tm_clk = 1'b0;
            #HALF;
            b[i]   = dio;
            tm_clk = 1'b1;
            #HALF;
        end
    endtask

    logic [15:0][7:0] exp_ram;
    logic [7:0]       rb;
    int               w0, f0, e0, l0;

    initial begin
        exp_ram = '0;

        #103;
        check_eq("rst_ram", display_ram, 128'h0);
        check_eq("rst_on", display_on, 1'b0);
        check_eq("rst_level", display_level, 3'd0);
        check_eq("rst_pulses", {ram_wr, frame_done, cmd_error}, 3'b000);
        check_eq("rst_dio_released", dio, 1'b1);
        rst = 1'b0;
        #200;

        // Auto-increment write of three bytes from address 0
        w0 = n_wr; f0 = n_frame; l0 = wr_log.size();
        frame1(8'h40);
        start_frame();
        send_bits(8'hC0, 8);
        send_bits(8'h3F, 8);
        send_bits(8'h06, 8);
        send_bits(8'h5B, 8);
        end_frame();
        exp_ram[0] = 8'h3F; exp_ram[1] = 8'h06; exp_ram[2] = 8'h5B;
        check_eq("auto_ram", display_ram, exp_ram);
        check_eq("auto_wr_count", n_wr - w0, 3);
        check_eq("auto_frames", n_frame - f0, 2);
        check_eq("auto_addrs", {wr_log[l0], wr_log[l0+1], wr_log[l0+2]}, 12'h012);

        // Fixed-address mode: second byte overwrites the first
        w0 = n_wr; l0 = wr_log.size();
        frame1(8'h44);
        start_frame();
        send_bits(8'hC5, 8);
        send_bits(8'hAA, 8);
        send_bits(8'h55, 8);
        end_frame();
        exp_ram[5] = 8'h55;
        check_eq("fixed_ram", display_ram, exp_ram);
        check_eq("fixed_addrs", {wr_log[l0], wr_log[l0+1]}, 8'h55);
        check_eq("fixed_wr_count", n_wr - w0, 2);

        // Address wrap 15 -> 0
        l0 = wr_log.size();
        frame1(8'h40);
        start_frame();
        send_bits(8'hCF, 8);
        send_bits(8'h11, 8);
        send_bits(8'h22, 8);
        end_frame();
        exp_ram[15] = 8'h11; exp_ram[0] = 8'h22;
        check_eq("wrap_ram", display_ram, exp_ram);
        check_eq("wrap_addrs", {wr_log[l0], wr_log[l0+1]}, 8'hF0);

        // Display control
        frame1(8'h8A);
        check_eq("disp_8a", {display_on, display_level}, 4'b1_010);
        frame1(8'h80);
        check_eq("disp_80", {display_on, display_level}, 4'b0_000);

        // Key read-back, LSB first, byte0 first
        key_scan = 32'h8001_4002;
        start_frame();
        send_bits(8'h42, 8);
        read_byte(rb); check_eq("read0", rb, 8'h02);
        read_byte(rb); check_eq("read1", rb, 8'h40);
        read_byte(rb); check_eq("read2", rb, 8'h01);
        read_byte(rb); check_eq("read3", rb, 8'h80);
        tm_clk = 1'b0; #HALF;
        check_eq("read_release_a", dio, 1'b1);
        tm_clk = 1'b1; #HALF;
        end_frame();
        check_eq("read_stb_release_a", dio, 1'b1);

        // All-zero keys: a stuck driver would read 0 against the pull-up
        key_scan = 32'h0000_0000;
        start_frame();
        send_bits(8'h42, 8);
        for (int k = 0; k < 4; k++) begin
            read_byte(rb);
            check_eq("read_zero", rb, 8'h00);
        end
        tm_clk = 1'b0; #HALF;
        check_eq("read_release_b", dio, 1'b1);
        tm_clk = 1'b1; #HALF;
        end_frame();
        check_eq("read_stb_release_b", dio, 1'b1);

        // Partial byte dropped on strobe release, then FSM accepts a new frame
        w0 = n_wr; f0 = n_frame;
        start_frame();
        send_bits(8'hC3, 8);
        send_bits(8'hAB, 5);
        end_frame();
        check_eq("partial_no_wr", n_wr - w0, 0);
        check_eq("partial_frame", n_frame - f0, 1);
        check_eq("partial_ram", display_ram, exp_ram);
        frame1(8'h8F);
        check_eq("idle_reentry", {display_on, display_level}, 4'b1_111);

        // Illegal and reserved commands
        e0 = n_err;
        frame1(8'h17);
        check_eq("err_class00", n_err - e0, 1);
        frame1(8'h41);
        check_eq("err_reserved", n_err - e0, 2);
        check_eq("err_ram", display_ram, exp_ram);

        // Write mode data without an address command is ignored
        w0 = n_wr;
        start_frame();
        send_bits(8'h40, 8);
        send_bits(8'h99, 8);
        end_frame();
        check_eq("noaddr_no_wr", n_wr - w0, 0);
        check_eq("noaddr_ram", display_ram, exp_ram);

        // Reset in the middle of a read while the device drives a 0
        key_scan = 32'h3C5A_96F0;
        start_frame();
        send_bits(8'h42, 8);
        for (int k = 0; k < 2; k++) begin
            tm_clk = 1'b0; #HALF;
            tm_clk = 1'b1; #HALF;
        end
        tm_clk = 1'b0; #HALF;
        check_eq("pre_rst_bit2", dio, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_dio", dio, 1'b1);
        check_eq("rst_mid_ram", display_ram, 128'h0);
        check_eq("rst_mid_disp", {display_on, display_level}, 4'b0_000);
        tm_clk = 1'b1;
        tm_stb = 1'b1;
        #200;
        rst = 1'b0;
        #200;
        start_frame();
        send_bits(8'h42, 8);
        read_byte(rb); check_eq("reread0", rb, 8'hF0);
        read_byte(rb); check_eq("reread1", rb, 8'h96);
        read_byte(rb); check_eq("reread2", rb, 8'h5A);
        read_byte(rb); check_eq("reread3", rb, 8'h3C);
        end_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
